// File: rtl/conv_pkg.sv
// Shared definitions for the 7x1 vertical convolution frame sequencer:
// FSM state encoding, default frame geometry and an output-count helper.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam int IMG_W_DEF = 220;
    localparam int IMG_H_DEF = 220;
    localparam int TAPS_DEF  = 7;

    // Number of valid convolution outputs in one frame: one per pixel of
    // every row that completes a full TAPS-row window.
    function automatic int expected_out_count(input int img_h, input int img_w, input int taps);
        return (img_h - taps + 1) * img_w;
    endfunction

endpackage

// File: rtl/conv71_frame_ctrl_if.sv
// Stream-side signals between the pixel source, the frame sequencer and the
// convolution datapath. The sequencer uses the master modport.
interface conv71_frame_ctrl_if #(
    parameter int CW = 8,
    parameter int RW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic          shift_en;
    logic          dp_clr;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          win_valid;
    logic          out_valid;

    modport master (
        input  in_valid,
        output in_ready, shift_en, dp_clr, col, row, win_valid, out_valid
    );

    modport slave (
        output in_valid,
        input  in_ready, shift_en, dp_clr, col, row, win_valid, out_valid
    );
endinterface

// File: rtl/valid_delay.sv
// Fixed-latency valid pipe: delays a single-bit flag by DEPTH cycles.
// Shifts every cycle regardless of any handshake so the delayed flag tracks
// a datapath whose latency is counted in clock cycles.
module valid_delay #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din_i,
    output logic dout_o
);
    logic [DEPTH-1:0] pipe_q;

    // Shift register advancing every cycle; reset flushes all stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_q <= {DEPTH{1'b0}};
        end else begin
            pipe_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign dout_o = pipe_q[DEPTH-1];
endmodule

// File: rtl/conv71_frame_ctrl.sv
// Frame sequencer for the streaming 7x1 vertical convolution datapath.
// Accepts raster-order pixels, drives the datapath advance enable, tracks
// row/col, flags completed windows and frames each image with clear/done.
module conv71_frame_ctrl
    import conv_pkg::*;
#(
    parameter int IMG_W    = IMG_W_DEF,
    parameter int IMG_H    = IMG_H_DEF,
    parameter int TAPS     = TAPS_DEF,
    parameter int PIPE_LAT = 2,
    parameter int CW       = $clog2(IMG_W),
    parameter int RW       = $clog2(IMG_H)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                frame_done,
    conv71_frame_ctrl_if.master bus
);
    localparam int DW = $clog2(PIPE_LAT + 1);
    // Row holding the last pixel before the first full window; unused when TAPS==1.
    localparam int FILL_ROW = (TAPS > 1) ? (TAPS - 2) : 0;

    localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_FILL_LAST = RW'(FILL_ROW);
    localparam state_e        FIRST_ST      = (TAPS > 1) ? FILL : RUN;

    state_e        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [DW-1:0] drain_q, drain_d;

    logic in_ready_s;
    logic shift_s;
    logic win_s;
    logic dp_clr_s;
    logic last_col_s;

    // Ready depends only on registered state (and reset), never on in_valid.
    assign in_ready_s = ((state_q == FILL) || (state_q == RUN)) && !reset;
    assign shift_s    = bus.in_valid && in_ready_s;
    assign last_col_s = (col_q == COL_LAST);

    // Next-state, raster position and drain counter; window flag and clear pulse.
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        drain_d  = drain_q;
        win_s    = 1'b0;
        dp_clr_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !reset) begin
                    dp_clr_s = 1'b1;
                    state_d  = FIRST_ST;
                end else begin
                    state_d  = IDLE;
                end
            end
            FILL: begin
                if (shift_s) begin
                    if (last_col_s) begin
                        col_d = {CW{1'b0}};
                        row_d = row_q + RW'(1);
                        if (row_q == ROW_FILL_LAST) begin
                            state_d = RUN;
                        end else begin
                            state_d = FILL;
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end else begin
                    state_d = FILL;
                end
            end
            RUN: begin
                win_s = shift_s;
                if (shift_s) begin
                    if (last_col_s && (row_q == ROW_LAST)) begin
                        col_d   = {CW{1'b0}};
                        row_d   = {RW{1'b0}};
                        drain_d = DW'(PIPE_LAT);
                        state_d = DRAIN;
                    end else if (last_col_s) begin
                        col_d = {CW{1'b0}};
                        row_d = row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                drain_d = drain_q - DW'(1);
                if (drain_q == DW'(1)) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                col_d   = {CW{1'b0}};
                row_d   = {RW{1'b0}};
                drain_d = {DW{1'b0}};
            end
        endcase
    end

    // State, position and drain counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            col_q   <= {CW{1'b0}};
            row_q   <= {RW{1'b0}};
            drain_q <= {DW{1'b0}};
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            drain_q <= drain_d;
        end
    end

    valid_delay #(
        .DEPTH (PIPE_LAT)
    ) u_valid_pipe (
        .clk    (clk),
        .reset  (reset),
        .din_i  (win_s),
        .dout_o (bus.out_valid)
    );

    assign bus.in_ready  = in_ready_s;
    assign bus.shift_en  = shift_s;
    assign bus.dp_clr    = dp_clr_s;
    assign bus.col       = col_q;
    assign bus.row       = row_q;
    assign bus.win_valid = win_s;
    assign busy          = (state_q != IDLE);
    assign frame_done    = (state_q == DONE);
endmodule

// File: tb/tb_conv71_frame_ctrl.sv
// Directed bench for conv71_frame_ctrl: a per-cycle vector table for frame
// start-up, raster/handshake sequences on a 4x8 instance, the full default
// 220x220 frame, and a TAPS==1 instance.
module tb_conv71_frame_ctrl;
    import conv_pkg::*;

    localparam int AW = 4;
    localparam int AH = 8;
    localparam int AT = 7;
    localparam int AL = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- DUT A: 4x8, TAPS 7, latency 2 ----------------
    logic rst_a, start_a, busy_a, done_a;
    conv71_frame_ctrl_if #(.CW(2), .RW(3)) bus_a ();
    conv71_frame_ctrl #(.IMG_W(AW), .IMG_H(AH), .TAPS(AT), .PIPE_LAT(AL)) dut_a (
        .clk(clk), .reset(rst_a), .start(start_a), .busy(busy_a),
        .frame_done(done_a), .bus(bus_a.master));

    // ---------------- DUT B: default geometry ----------------
    logic rst_b, start_b, busy_b, done_b;
    conv71_frame_ctrl_if #(.CW(8), .RW(8)) bus_b ();
    conv71_frame_ctrl dut_b (
        .clk(clk), .reset(rst_b), .start(start_b), .busy(busy_b),
        .frame_done(done_b), .bus(bus_b.master));

    // ---------------- DUT C: 4x2, TAPS 1 ----------------
    logic rst_c, start_c, busy_c, done_c;
    conv71_frame_ctrl_if #(.CW(2), .RW(1)) bus_c ();
    conv71_frame_ctrl #(.IMG_W(4), .IMG_H(2), .TAPS(1), .PIPE_LAT(2)) dut_c (
        .clk(clk), .reset(rst_c), .start(start_c), .busy(busy_c),
        .frame_done(done_c), .bus(bus_c.master));

    typedef struct {
        logic       st;  logic iv;
        logic       rdy; logic sh; logic clr; logic bsy;
        logic       win; logic outv; logic dn;
        logic [1:0] col; logic [2:0] row;
    } vec_t;
    vec_t tbl[8];

    // Raster model and frame statistics for DUT A
    int m_row, m_col, shifts, outs, clrs;
    int start_cyc, first_shift, first_out, last_shift, done_cyc;
    logic h1, h2;

    task automatic frame_a(input bit do_start, input bit rand_iv, input bit pokes,
                           input int abort_row, input int abort_col, output bit aborted);
        int  budget;
        int  done_cd;
        bit  fin;
        aborted = 1'b0; fin = 1'b0; done_cd = -1; budget = 0;
        if (do_start) begin
            start_a = 1'b1; bus_a.in_valid = 1'b1;
            @(negedge clk);
            start_cyc = cyc;
            check("start_clr", bus_a.dp_clr, 1);
            check("start_rdy", bus_a.in_ready, 0);
            check("start_busy", busy_a, 0);
            @(posedge clk); #1;
            m_row = 0; m_col = 0; shifts = 0; outs = 0; clrs = 0;
            h1 = 1'b0; h2 = 1'b0; first_shift = -1; first_out = -1;
        end
        while (!fin) begin
            if (m_row == abort_row && m_col == abort_col) begin
                aborted = 1'b1; fin = 1'b1;
            end else begin
                if (done_cd > 0) done_cd--;
                start_a = pokes && (done_cd == 0 || $urandom_range(0, 5) == 0);
                bus_a.in_valid = rand_iv ? 1'($urandom_range(0, 1)) : 1'b1;
                @(negedge clk);
                check("busy", busy_a, 1);
                check("shift_eq", bus_a.shift_en, bus_a.in_valid & bus_a.in_ready);
                if (done_cd >= 0) check("drain_rdy", bus_a.in_ready, 0);
                if (bus_a.dp_clr) clrs++;
                if (bus_a.shift_en) begin
                    if (first_shift < 0) first_shift = cyc;
                    check("raster_col", bus_a.col, m_col);
                    check("raster_row", bus_a.row, m_row);
                    check("win_valid", bus_a.win_valid, (m_row >= AT - 1) ? 1 : 0);
                    shifts++; last_shift = cyc;
                    if (m_col == AW - 1) begin
                        m_col = 0; m_row++;
                        if (m_row == AH) begin m_row = 0; done_cd = AL + 1; end
                    end else begin
                        m_col++;
                    end
                end else begin
                    check("win_noshift", bus_a.win_valid, 0);
                end
                check("out_align", bus_a.out_valid, h2);
                if (bus_a.out_valid) begin
                    outs++;
                    if (first_out < 0) first_out = cyc;
                end
                h2 = h1; h1 = bus_a.win_valid;
                if (done_a) begin
                    done_cyc = cyc; fin = 1'b1;
                    check("done_lat", done_cyc - last_shift, AL + 1);
                end else if (++budget > 500) begin
                    n_checks++; n_fail++;
                    $display("FAIL frame_timeout: got no frame_done expected one within 500 cycles");
                    fin = 1'b1;
                end
                @(posedge clk); #1;
            end
        end
        start_a = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ab;
        int prev_done;
        int b_sh, b_out, b_first_out, b_last, b_done, sb, sc, c_sh, c_win, c_out, c_first_win, c_last, c_done;

        tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 3'd0};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 3'd0};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd1};

        rst_a = 1'b1; start_a = 1'b0; bus_a.in_valid = 1'b0;
        rst_b = 1'b1; start_b = 1'b0; bus_b.in_valid = 1'b0;
        rst_c = 1'b1; start_c = 1'b0; bus_c.in_valid = 1'b0;
        @(posedge clk); #1;
        // reset and start together: reset wins
        start_a = 1'b1; bus_a.in_valid = 1'b1;
        @(negedge clk);
        check("rst_start_clr", bus_a.dp_clr, 0);
        @(posedge clk); #1;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        // ---- table-driven start-up of frame 1 on DUT A ----
        for (int i = 0; i < 8; i++) begin
            start_a = tbl[i].st; bus_a.in_valid = tbl[i].iv;
            @(negedge clk);
            check($sformatf("tbl%0d_rdy", i),  bus_a.in_ready,  tbl[i].rdy);
            check($sformatf("tbl%0d_sh", i),   bus_a.shift_en,  tbl[i].sh);
            check($sformatf("tbl%0d_clr", i),  bus_a.dp_clr,    tbl[i].clr);
            check($sformatf("tbl%0d_busy", i), busy_a,          tbl[i].bsy);
            check($sformatf("tbl%0d_win", i),  bus_a.win_valid, tbl[i].win);
            check($sformatf("tbl%0d_out", i),  bus_a.out_valid, tbl[i].outv);
            check($sformatf("tbl%0d_done", i), done_a,          tbl[i].dn);
            check($sformatf("tbl%0d_col", i),  bus_a.col,       tbl[i].col);
            check($sformatf("tbl%0d_row", i),  bus_a.row,       tbl[i].row);
            @(posedge clk); #1;
        end
        m_row = 1; m_col = 1; shifts = 5; outs = 0; clrs = 0; h1 = 1'b0; h2 = 1'b0;

        // ---- rest of frame 1: random in_valid, start pokes incl. DONE cycle ----
        frame_a(1'b0, 1'b1, 1'b1, -1, -1, ab);
        check("f1_shifts", shifts, 32);
        check("f1_outs", outs, expected_out_count(AH, AW, AT));
        check("f1_poke_clr", clrs, 0);
        start_a = 1'b0; bus_a.in_valid = 1'b1;
        @(negedge clk);
        check("post_done_busy", busy_a, 0);
        check("post_done_rdy", bus_a.in_ready, 0);
        check("post_done_sh", bus_a.shift_en, 0);
        check("post_done_done", done_a, 0);
        @(posedge clk); #1;

        // ---- frame 2: in_valid high, latency of first shift/out ----
        frame_a(1'b1, 1'b0, 1'b0, -1, -1, ab);
        check("f2_shifts", shifts, 32);
        check("f2_outs", outs, 8);
        check("f2_first_shift", first_shift - start_cyc, 1);
        check("f2_first_out", first_out - start_cyc, 27);
        prev_done = done_cyc;

        // ---- frame 3: back-to-back start at frame_done+1 ----
        frame_a(1'b1, 1'b0, 1'b0, -1, -1, ab);
        check("b2b_start", start_cyc - prev_done, 1);
        check("b2b_first_shift", first_shift - prev_done, 2);
        check("f3_shifts", shifts, 32);
        check("f3_outs", outs, 8);
        check("f3_clr", clrs, 0);

        // ---- frame 4: reset at row 3 col 2 ----
        frame_a(1'b1, 1'b1, 1'b0, 3, 2, ab);
        check("abort_reached", ab, 1);
        rst_a = 1'b1; start_a = 1'b1; bus_a.in_valid = 1'b1;
        @(negedge clk);
        check("abort_rst_clr", bus_a.dp_clr, 0);
        @(posedge clk); #1;
        rst_a = 1'b0; start_a = 1'b0;
        @(negedge clk);
        check("abort_busy", busy_a, 0);
        check("abort_rdy", bus_a.in_ready, 0);
        check("abort_sh", bus_a.shift_en, 0);
        check("abort_win", bus_a.win_valid, 0);
        check("abort_col", bus_a.col, 0);
        check("abort_row", bus_a.row, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_out", bus_a.out_valid, 0);
            check("abort_done", done_a, 0);
            @(posedge clk); #1;
        end

        // ---- frame 5: fresh full frame after abort ----
        frame_a(1'b1, 1'b1, 1'b0, -1, -1, ab);
        check("f5_shifts", shifts, 32);
        check("f5_outs", outs, 8);

        // ---- DUT B: full default frame ----
        b_sh = 0; b_out = 0; b_first_out = -1; b_last = -1; b_done = -1; sb = -1;
        start_b = 1'b1; bus_b.in_valid = 1'b1;
        for (int i = 0; i < 60000 && b_done < 0; i++) begin
            @(negedge clk);
            if (i == 0) sb = cyc;
            if (bus_b.shift_en) begin b_sh++; b_last = cyc; end
            if (bus_b.out_valid) begin
                b_out++;
                if (b_first_out < 0) b_first_out = cyc;
            end
            if (done_b) b_done = cyc;
            @(posedge clk); #1;
            start_b = 1'b0;
        end
        check("b_shifts", b_sh, 48400);
        check("b_outs", b_out, 47080);
        check("b_first_out", b_first_out - sb, 1323);
        check("b_done_lat", b_done - b_last, 3);

        // ---- DUT C: TAPS 1 skips FILL ----
        c_sh = 0; c_win = 0; c_out = 0; c_first_win = -1; c_last = -1; c_done = -1; sc = -1;
        start_c = 1'b1; bus_c.in_valid = 1'b1;
        for (int i = 0; i < 100 && c_done < 0; i++) begin
            @(negedge clk);
            if (i == 0) sc = cyc;
            check("c_win_eq_shift", bus_c.win_valid, bus_c.shift_en);
            if (bus_c.shift_en) begin c_sh++; c_last = cyc; end
            if (bus_c.win_valid) begin
                c_win++;
                if (c_first_win < 0) c_first_win = cyc;
            end
            if (bus_c.out_valid) c_out++;
            if (done_c) c_done = cyc;
            @(posedge clk); #1;
            start_c = 1'b0;
        end
        check("c_shifts", c_sh, 8);
        check("c_wins", c_win, 8);
        check("c_outs", c_out, expected_out_count(2, 4, 1));
        check("c_first_win", c_first_win - sc, 1);
        check("c_done_lat", c_done - c_last, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/conv71_frame_ctrl.md
# conv71_frame_ctrl

Frame sequencer for the streaming 7x1 vertical convolution datapath. It accepts a raster-order pixel stream through a valid/ready handshake and drives the datapath's line-buffer/shift-register advance enable. It tracks row and column position, flags when the 7-row window is fully populated, and re-times that flag through the datapath latency to produce the output valid. It also frames each image with a datapath clear pulse at start and a done pulse at end. It sits between the pixel source and the convolution datapath, replacing free-running per-clock shifting.

## Interface
Parameters:
- IMG_W, 220, pixels per row (line-buffer length)
- IMG_H, 220, rows per frame
- TAPS, 7, vertical kernel height; TAPS <= IMG_H
- PIPE_LAT, 2, cycles from shift_en to the datapath's pxl_out; PIPE_LAT >= 1
- CW, $clog2(IMG_W), column counter width
- RW, $clog2(IMG_H), row counter width

Ports:
- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- start  in  1  pulse; begins a frame when idle, ignored otherwise
- in_valid  in  1  source has a pixel on the datapath pxl_in
- in_ready  out  1  controller accepts a pixel this cycle
- shift_en  out  1  = in_valid & in_ready; datapath advances its shift registers and line buffers
- dp_clr  out  1  one-cycle pulse that clears datapath shift registers and line buffers
- col  out  CW  column of the pixel accepted on the current shift_en
- row  out  RW  row of the pixel accepted on the current shift_en
- win_valid  out  1  current shift_en completes a window of TAPS valid rows
- out_valid  out  1  datapath pxl_out is valid (win_valid delayed PIPE_LAT cycles)
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse after the last out_valid of a frame

## Operation
- The FSM has five states: IDLE, FILL, RUN, DRAIN, DONE.
- IDLE:
  - in_ready=0; row and col held at 0.
  - On start, assert dp_clr in the same cycle and go to FILL.
- FILL:
  - in_ready=1; win_valid=0.
  - Each shift_en advances col; col wraps from IMG_W-1 to 0 and increments row.
  - Leave for RUN when the pixel at (TAPS-2, IMG_W-1) is accepted.
  - If TAPS==1, go directly from IDLE to RUN.
- RUN:
  - in_ready=1; win_valid=shift_en.
  - Accepting (IMG_H-1, IMG_W-1) moves the FSM to DRAIN; row and col return to 0.
- DRAIN:
  - in_ready=0.
  - A down-counter loaded with PIPE_LAT decrements each cycle; at 1, go to DONE.
- DONE:
  - frame_done=1 for exactly one cycle, then go to IDLE.
- in_valid low stalls everything: no shift_en and no counter change. The valid pipe keeps shifting, so out_valid stays aligned with datapath latency, not with the handshake.
- The valid pipe is a PIPE_LAT-deep shift register of win_valid, shifting every cycle.
- Exactly (IMG_H-TAPS+1)*IMG_W out_valid pulses occur per frame.
- start outside IDLE is ignored, including in the DONE cycle.

## Timing
- Reset values:
  - state=IDLE; row=col=0; drain counter=0; valid pipe all 0.
  - All outputs are 0: in_ready, shift_en, dp_clr, win_valid, out_valid, busy, frame_done.
- in_ready, busy and dp_clr decode combinationally from registered state and start. No combinational path from in_valid to in_ready.
- FILL is entered on the cycle after start, so the first possible shift_en is start+1.
- With the last shift_en at cycle t:
  - DRAIN occupies t+1..t+PIPE_LAT.
  - The last out_valid occurs at t+PIPE_LAT.
  - frame_done fires at t+PIPE_LAT+1.
  - IDLE is reached at t+PIPE_LAT+2.
- A back-to-back frame: start is sampled in IDLE at t+PIPE_LAT+2, and its first pixel can be accepted at t+PIPE_LAT+3.
- Reset mid-frame: the next cycle is IDLE, the pipe is flushed, no frame_done is produced, and no further out_valid appears.
- reset and start in the same cycle: reset wins and dp_clr stays 0.

## Structure
- Shared package conv_pkg holds:
  - the state enum (IDLE, FILL, RUN, DRAIN, DONE);
  - default IMG_W, IMG_H and TAPS constants;
  - a helper function computing the expected output count.
- One sub-module, valid_delay (parameter DEPTH, synchronous-reset shift register), implements the valid pipe. It is reusable for other kernels' datapaths.

## Test plan
- Default parameters, in_valid held high, one start:
  - 48400 shift_en and 47080 out_valid pulses.
  - First out_valid at start+1+6*220+2 = start+1323.
  - frame_done exactly 3 cycles after the last shift_en.
- IMG_W=4, IMG_H=8, PIPE_LAT=2, random in_valid (50%):
  - 32 shift_en and 8 out_valid pulses.
  - row/col sequence matches raster order.
  - out_valid is always exactly 2 cycles after a win_valid.
- start pulsed during FILL, RUN and DONE: ignored; no second dp_clr; counters are unaffected.
- Reset asserted at row 3, col 2 (IMG_W=4, IMG_H=8):
  - next cycle state=IDLE, all outputs 0, no frame_done.
  - a fresh start then yields a full, correct frame.
- Two back-to-back frames: the second start is accepted at frame_done+1, and each frame produces dp_clr once and the full out_valid count.
- TAPS=1, IMG_W=4, IMG_H=2: FILL is skipped, and all 8 shift_en produce win_valid.
